// File: rtl/hit_tracker.sv
// Purpose: pairs each lit-light window with key presses; counts hits and misses and manages lives.
// Latency: one cycle from the sampled light/key change to the registered counters and strobes.
// Backpressure: none; inputs are level signals sampled every cycle and no input is ever stalled.
// Ports:
//   clk, reset (async active-low)
//   enable, load, use_lives, total_lives   game control from the top-level FSM
//   light_on/light_pos, key_down/key_pressed   light and keypad controller levels
//   points, misses, lives_left, hit_pulse, miss_pulse (registered), out_of_lives (decoded)
module hit_tracker #(
  parameter int POINT_WIDTH = 6,
  parameter int MAX_LIVES   = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   load,
  input  logic                   use_lives,
  input  logic [3:0]             total_lives,
  input  logic                   light_on,
  input  logic [3:0]             light_pos,
  input  logic                   key_down,
  input  logic [3:0]             key_pressed,
  output logic [POINT_WIDTH-1:0] points,
  output logic [POINT_WIDTH-1:0] misses,
  output logic [3:0]             lives_left,
  output logic                   hit_pulse,
  output logic                   miss_pulse,
  output logic                   out_of_lives
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    SCORED = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam logic [POINT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [3:0]             LIVES_CAP = 4'(MAX_LIVES);

  state_t                 state, state_nx;
  logic [3:0]             target, target_nx;
  logic                   light_q, key_q;
  logic [POINT_WIDTH-1:0] points_nx, misses_nx;
  logic [3:0]             lives_nx;
  logic                   hit_nx, miss_nx;

  logic open_evt, close_evt, press_evt;

  // Edge detectors run regardless of enable, so a light already lit when
  // enable rises never produces an open edge and is not armed.
  assign open_evt  = light_on & ~light_q;
  assign close_evt = ~light_on & light_q;
  assign press_evt = key_down & ~key_q;

  assign out_of_lives = use_lives & (lives_left == 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      target     <= 4'd0;
      light_q    <= 1'b0;
      key_q      <= 1'b0;
      points     <= '0;
      misses     <= '0;
      lives_left <= 4'd0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      target     <= target_nx;
      light_q    <= light_on;
      key_q      <= key_down;
      points     <= points_nx;
      misses     <= misses_nx;
      lives_left <= lives_nx;
      hit_pulse  <= hit_nx;
      miss_pulse <= miss_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    target_nx = target;
    points_nx = points;
    misses_nx = misses;
    lives_nx  = lives_left;
    hit_nx    = 1'b0;
    miss_nx   = 1'b0;

    if (load) begin
      state_nx  = IDLE;
      points_nx = '0;
      misses_nx = '0;
      lives_nx  = (total_lives > LIVES_CAP) ? LIVES_CAP : total_lives;
    end else if (!enable) begin
      // Leaving PLAY abandons any open window without counting it.
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!close_evt && open_evt) begin
            target_nx = light_pos;
            state_nx  = ARMED;
          end
        end
        ARMED: begin
          // Close outranks press: a press on the closing edge is a miss.
          if (!close_evt && press_evt) begin
            if (key_pressed == target) begin
              points_nx = (points == CNT_MAX) ? points : points + 1'b1;
              hit_nx    = 1'b1;
              state_nx  = SCORED;
            end else begin
              state_nx = LOCKED;
            end
          end
        end
        SCORED: begin
          if (close_evt) state_nx = IDLE;
        end
        LOCKED: begin
          // Missed-window accounting is shared with ARMED below.
        end
        default: state_nx = IDLE;
      endcase

      if ((state == ARMED || state == LOCKED) && close_evt) begin
        misses_nx = (misses == CNT_MAX) ? misses : misses + 1'b1;
        miss_nx   = 1'b1;
        if (use_lives && lives_left != 4'd0) lives_nx = lives_left - 4'd1;
        state_nx  = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_hit_tracker.sv
// Purpose: directed self-checking bench for hit_tracker.
// Latency: checks are made after settling gaps, strobes are counted by a monitor.
// Backpressure: not applicable; all stimulus is level-driven on the falling edge.
module tb_hit_tracker;

  logic       clock_50;
  logic       reset;
  logic       enable;
  logic       load;
  logic       use_lives;
  logic [3:0] total_lives;
  logic       light_on;
  logic [3:0] light_pos;
  logic       key_down;
  logic [3:0] key_pressed;
  logic [5:0] points;
  logic [5:0] misses;
  logic [3:0] lives_left;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       out_of_lives;

  int checks = 0;
  int errors = 0;
  int hit_cnt = 0;
  int miss_cnt = 0;
  int h0, m0;

  hit_tracker #(.POINT_WIDTH(6), .MAX_LIVES(9)) dut (
    .clk          (clock_50),
    .reset        (reset),
    .enable       (enable),
    .load         (load),
    .use_lives    (use_lives),
    .total_lives  (total_lives),
    .light_on     (light_on),
    .light_pos    (light_pos),
    .key_down     (key_down),
    .key_pressed  (key_pressed),
    .points       (points),
    .misses       (misses),
    .lives_left   (lives_left),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse),
    .out_of_lives (out_of_lives)
  );

  initial clock_50 = 1'b0;
  always #10 clock_50 = ~clock_50;

  // Each strobe is high for one full cycle, so one sample per negedge counts it once.
  always @(negedge clock_50) begin
    if (hit_pulse)  hit_cnt++;
    if (miss_pulse) miss_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock_50);
  endtask

  task automatic do_load(input logic [3:0] lives);
    total_lives = lives;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(1);
  endtask

  task automatic open_win(input logic [3:0] pos);
    light_pos = pos;
    light_on  = 1'b1;
    cyc(2);
  endtask

  task automatic close_win();
    light_on = 1'b0;
    cyc(2);
  endtask

  task automatic press(input logic [3:0] k);
    key_pressed = k;
    key_down    = 1'b1;
    cyc(2);
    key_down = 1'b0;
    cyc(2);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; load = 1'b0; use_lives = 1'b1;
    total_lives = 4'd0; light_on = 1'b0; light_pos = 4'd0;
    key_down = 1'b0; key_pressed = 4'd0;
    #1;
    check("rst_points", points, 0);
    check("rst_misses", misses, 0);
    check("rst_lives", lives_left, 0);
    check("rst_hit", hit_pulse, 0);
    check("rst_miss", miss_pulse, 0);
    check("rst_oor", out_of_lives, 1);
    cyc(2);
    reset = 1'b1;
    cyc(1);

    // Single correct hit.
    enable = 1'b1;
    do_load(4'd3);
    h0 = hit_cnt; m0 = miss_cnt;
    open_win(4'd4); press(4'd4); close_win();
    check("hit_pulses", hit_cnt - h0, 1);
    check("hit_points", points, 1);
    check("hit_misses", misses, 0);
    check("hit_lives", lives_left, 3);

    // Wrong key locks the window; later correct key is ignored.
    h0 = hit_cnt; m0 = miss_cnt;
    open_win(4'd2); press(4'd5); press(4'd2); close_win();
    check("wrong_hits", hit_cnt - h0, 0);
    check("wrong_miss_pulses", miss_cnt - m0, 1);
    check("wrong_misses", misses, 1);
    check("wrong_lives", lives_left, 2);
    check("wrong_points", points, 1);

    // Lives clamp and exhaustion.
    do_load(4'd12);
    check("clamp_lives", lives_left, 9);
    check("clamp_oor", out_of_lives, 0);
    m0 = miss_cnt;
    for (int i = 0; i < 9; i++) begin
      open_win(4'd0); close_win();
    end
    check("exh_lives", lives_left, 0);
    check("exh_oor", out_of_lives, 1);
    check("exh_misses9", misses, 9);
    open_win(4'd0); close_win();
    check("exh_misses10", misses, 10);
    check("exh_lives_floor", lives_left, 0);
    check("exh_miss_pulses", miss_cnt - m0, 10);

    // Correct press on the same cycle the light drops counts as a miss.
    do_load(4'd3);
    h0 = hit_cnt;
    open_win(4'd7);
    key_pressed = 4'd7; key_down = 1'b1; light_on = 1'b0;
    cyc(2);
    key_down = 1'b0;
    cyc(2);
    check("coll_points", points, 0);
    check("coll_misses", misses, 1);
    check("coll_lives", lives_left, 2);
    check("coll_hits", hit_cnt - h0, 0);

    // Points saturation: strobes keep firing while the counter holds.
    use_lives = 1'b0;
    do_load(4'd3);
    h0 = hit_cnt;
    for (int i = 0; i < 64; i++) begin
      open_win(4'(i % 9)); press(4'(i % 9)); close_win();
    end
    check("sat_points", points, 63);
    check("sat_hit_pulses", hit_cnt - h0, 64);
    check("sat_misses", misses, 0);
    check("sat_oor", out_of_lives, 0);

    // A key held across two windows scores only the first.
    do_load(4'd3);
    open_win(4'd3);
    key_pressed = 4'd3; key_down = 1'b1;
    cyc(2);
    close_win();
    open_win(4'd3);
    close_win();
    key_down = 1'b0;
    cyc(2);
    check("held_points", points, 1);
    check("held_misses", misses, 1);

    // Enable drop abandons a window; enabling under a lit light ignores it.
    use_lives = 1'b1;
    do_load(4'd3);
    h0 = hit_cnt; m0 = miss_cnt;
    open_win(4'd1);
    enable = 1'b0;
    cyc(2);
    close_win();
    enable = 1'b1;
    cyc(2);
    enable = 1'b0;
    light_pos = 4'd6; light_on = 1'b1;
    cyc(2);
    enable = 1'b1;
    cyc(2);
    press(4'd6);
    close_win();
    check("en_points", points, 0);
    check("en_misses", misses, 0);
    check("en_lives", lives_left, 3);
    check("en_hits", hit_cnt - h0, 0);
    check("en_miss_pulses", miss_cnt - m0, 0);

    // Reset while armed clears everything at once and emits no strobe.
    open_win(4'd8); press(4'd8); close_win();
    check("pre_rst_points", points, 1);
    open_win(4'd2);
    m0 = miss_cnt;
    reset = 1'b0;
    #1;
    check("arst_points", points, 0);
    check("arst_misses", misses, 0);
    check("arst_lives", lives_left, 0);
    check("arst_hit", hit_pulse, 0);
    check("arst_miss", miss_pulse, 0);
    check("arst_oor", out_of_lives, 1);
    cyc(2);
    light_on = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(3);
    check("arst_no_miss", miss_cnt - m0, 0);
    check("arst_misses_after", misses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
